kb_scr_fifo_drv: RTL
====================

KB_SCR_FIFO_DRV -- requirements
Module: kb_scr_fifo_drv

Interface
REQ-001 SHALL have parameter DATA_W, default 8: width of every data path.
REQ-002 SHALL have parameter DEPTH, default 4, power of two >= 2: entries per direction FIFO.
REQ-003 SHALL have ports: clk  in  1  sole clock, all logic on rising edge.
REQ-004 SHALL have ports: rst  in  1  reset, synchronous, active-high.
REQ-005 SHALL have ports: kb_data_i  in  DATA_W  keyboard byte; kb_valid_i  in  1  byte present; kb_ready_o  out  1  accept.
REQ-006 SHALL have ports: scr_data_o  out  DATA_W  screen byte; scr_valid_o  out  1  byte present; scr_ready_i  in  1  screen accepts.
REQ-007 SHALL have ports: csr_kb_i, csr_scr_i  in  8  CPU CSR image (bit4 ena, bit3 of, bit2 dba, bit1 io, bit0 ie).
REQ-008 SHALL have ports: csr_kb_o, csr_scr_o  out  8  status CSR image, same bit layout.
REQ-009 SHALL have ports: kb_rd_i  in  1  CPU pops kb head; data_reg_kb_o  out  DATA_W  kb FIFO head.
REQ-010 SHALL have ports: scr_wr_i  in  1  CPU pushes data_reg_scr_i  in  DATA_W.
REQ-011 SHALL have ports: of_clr_i  in  2  CPU clears of flag ([1] scr, [0] kb); irq_o  out  1  interrupt (see Configuration).

Function
REQ-012 kb_ready_o SHALL equal csr_kb_i[4] (ena); handshake completes when kb_valid_i && kb_ready_o on a clock edge.
REQ-013 Accepted kb byte SHALL be written to kb FIFO tail; if FIFO full and no same-cycle pop, byte SHALL be dropped and kb of set.
REQ-014 Push and pop on full kb FIFO in same cycle SHALL both succeed, count unchanged, of unchanged.
REQ-015 kb_rd_i on empty kb FIFO SHALL be ignored; data_reg_kb_o SHALL show head combinationally from storage, 0 when empty.
REQ-016 kb dba (csr_kb_o[2]) SHALL be 1 iff kb FIFO non-empty; latency from accepting edge to dba=1 is one cycle.
REQ-017 scr_wr_i with csr_scr_i[4]=1 SHALL push data_reg_scr_i; if scr FIFO full and no same-cycle pop, byte dropped, scr of set.
REQ-018 scr_valid_o SHALL be 1 iff scr FIFO non-empty and scr ena=1; pop on scr_valid_o && scr_ready_i.
REQ-019 scr_data_o SHALL present head data unmodified (no inversion); stable while scr_valid_o && !scr_ready_i.
REQ-020 scr dba (csr_scr_o[2]) SHALL be 1 iff scr FIFO not full (space available).
REQ-021 of flags SHALL be sticky until of_clr_i bit asserted; clear and new overflow same cycle SHALL leave of=1.
REQ-022 Deasserting ena SHALL freeze that direction's handshakes; FIFO contents retained.
REQ-023 csr_*_o bits 4,1,0 SHALL pass csr_*_i through registered one cycle; bits 3,2 driven by the block.
REQ-024 Pointers SHALL be log2(DEPTH) bits wrapping modulo DEPTH; count SHALL be log2(DEPTH)+1 bits, range 0..DEPTH.

Reset
REQ-025 On rst edge: both FIFOs empty, of flags 0, kb_ready_o follows input, scr_valid_o 0, data_reg_kb_o 0, csr_kb_o 0x00, csr_scr_o 0x04, irq_o 0.
REQ-026 rst mid-transfer SHALL discard all buffered bytes; a handshake coincident with rst SHALL be lost.

Configuration
REQ-027 With KB_SCR_FIFO_IRQ_EN defined, irq_o SHALL be registered: (kb ie && kb dba) || (scr ie && scr dba && scr ena).
REQ-028 Without KB_SCR_FIFO_IRQ_EN, irq_o SHALL be tied 0 and ie bits only passed through.

Structure
REQ-029 Package kb_scr_pkg SHALL hold CSR bit indices (ENA=4, OF=3, DBA=2, IO=1, IE=0) and csr reset constants.
REQ-030 One sub-module sync_fifo (params DATA_W, DEPTH; push/pop/full/empty/count/head) SHALL be instantiated twice.

Verification
REQ-031 ena=1, push 0x41 on kb -> next cycle dba=1, data_reg_kb_o=0x41; kb_rd_i -> dba=0.
REQ-032 DEPTH=4, push 5 kb bytes 0x01..0x05 no pops -> of=1, pops return 0x01..0x04, 0x05 lost.
REQ-033 kb full, push 0x99 + kb_rd_i same cycle -> of=0, count stays 4, last pop returns 0x99.
REQ-034 scr_ready_i=0, CPU writes 0x10,0x20 -> scr_valid_o=1, data 0x10 held; ready=1 -> 0x10 then 0x20, valid=0, dba=1.
REQ-035 Fill scr FIFO, assert rst mid-stream -> next cycle scr_valid_o=0, csr_scr_o=0x04, csr_kb_o=0x00.
REQ-036 IRQ_EN build, kb ie=1, push 0x55 -> irq_o=1 two cycles after handshake; pop -> irq_o=0; non-IRQ build irq_o=0 throughout.

Source files
------------

// File: rtl/kb_scr_pkg.sv
// -----------------------------------------------------------------------------
// kb_scr_pkg
// Shared definitions for the keyboard/screen FIFO driver:
//   - CSR bit indices (ENA, OF, DBA, IO, IE) common to both directions
//   - CSR reset images and the mask of CPU-owned (pass-through) bits
//   - csr_image(): assembles a status CSR from the registered CPU bits plus
//     the block-owned overflow and data-buffer-available flags
// -----------------------------------------------------------------------------
package kb_scr_pkg;

  localparam int CSR_ENA = 4;
  localparam int CSR_OF  = 3;
  localparam int CSR_DBA = 2;
  localparam int CSR_IO  = 1;
  localparam int CSR_IE  = 0;

  localparam logic [7:0] CSR_KB_RST  = 8'h00;
  localparam logic [7:0] CSR_SCR_RST = 8'h04;

  // Bits the CPU owns and that are echoed back one cycle later (ena, io, ie).
  localparam logic [7:0] CSR_PASS_MASK = 8'h13;

  function automatic logic [7:0] csr_image(input logic [7:0] pass_q,
                                           input logic       of_flag,
                                           input logic       dba_flag);
    logic [7:0] img;
    img          = pass_q & CSR_PASS_MASK;
    img[CSR_OF]  = of_flag;
    img[CSR_DBA] = dba_flag;
    return img;
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// -----------------------------------------------------------------------------
// sync_fifo
// Single-clock FIFO with synchronous active-high reset. A push into a full
// FIFO is accepted only when a pop happens in the same cycle; a pop on an
// empty FIFO is ignored. head_o shows the storage slot at the read pointer.
// Ports:
//   clk, rst          clock, synchronous active-high reset
//   push_i, data_i    write request and data
//   pop_i             read request (removes head)
//   head_o            current head entry (undefined contents when empty)
//   full_o, empty_o   occupancy flags
//   count_o           number of entries, 0..DEPTH
// -----------------------------------------------------------------------------
module sync_fifo #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push_i,
  input  logic                     pop_i,
  input  logic [DATA_W-1:0]        data_i,
  output logic [DATA_W-1:0]        head_o,
  output logic                     full_o,
  output logic                     empty_o,
  output logic [$clog2(DEPTH):0]   count_o
);

  localparam int PTR_W = $clog2(DEPTH);

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [PTR_W:0]    count_q, count_d;
  logic              do_push, do_pop;

  assign empty_o = (count_q == '0);
  assign full_o  = (count_q == (PTR_W+1)'(DEPTH));
  assign count_o = count_q;
  assign head_o  = mem_q[rd_ptr_q];

  // Full-and-pop frees the head slot in the same edge, so the push may land.
  assign do_pop  = pop_i && !empty_o;
  assign do_push = push_i && (!full_o || do_pop);

  // NOTE: every always_comb output gets a default first so no path leaves it
  // unassigned; otherwise synthesis infers a latch.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
    if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // NOTE: storage is deliberately not reset; the pointers and count define
  // validity, and a resettable array would cost a mux per bit.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= data_i;
  end

endmodule

// File: rtl/kb_scr_fifo_drv.sv
// -----------------------------------------------------------------------------
// kb_scr_fifo_drv
// Keyboard-to-CPU and CPU-to-screen byte buffering with CSR status images.
// Optional feature macro: KB_SCR_FIFO_IRQ_EN (registered interrupt output);
// when undefined irq_o is tied low and ie bits are only echoed.
// Ports:
//   clk, rst                      clock, synchronous active-high reset
//   kb_data_i/kb_valid_i/kb_ready_o     keyboard byte stream in
//   scr_data_o/scr_valid_o/scr_ready_i  screen byte stream out
//   csr_kb_i, csr_scr_i           CPU CSR images (ena, of, dba, io, ie)
//   csr_kb_o, csr_scr_o           status CSR images, same layout
//   kb_rd_i, data_reg_kb_o        CPU pop of kb FIFO head / head value
//   scr_wr_i, data_reg_scr_i      CPU push into scr FIFO
//   of_clr_i                      overflow clears ([1] scr, [0] kb)
//   irq_o                         interrupt
// -----------------------------------------------------------------------------
module kb_scr_fifo_drv
  import kb_scr_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] kb_data_i,
  input  logic              kb_valid_i,
  output logic              kb_ready_o,
  output logic [DATA_W-1:0] scr_data_o,
  output logic              scr_valid_o,
  input  logic              scr_ready_i,
  input  logic [7:0]        csr_kb_i,
  input  logic [7:0]        csr_scr_i,
  output logic [7:0]        csr_kb_o,
  output logic [7:0]        csr_scr_o,
  input  logic              kb_rd_i,
  output logic [DATA_W-1:0] data_reg_kb_o,
  input  logic              scr_wr_i,
  input  logic [DATA_W-1:0] data_reg_scr_i,
  input  logic [1:0]        of_clr_i,
  output logic              irq_o
);

  localparam int CNT_W = $clog2(DEPTH) + 1;

  logic              kb_full, kb_empty, scr_full, scr_empty;
  logic [CNT_W-1:0]  kb_count, scr_count;
  logic [DATA_W-1:0] kb_head, scr_head;
  logic              kb_push, kb_pop, kb_ovf;
  logic              scr_push, scr_pop, scr_ovf;
  logic              kb_dba, scr_dba;
  logic              of_kb_q, of_kb_d, of_scr_q, of_scr_d;
  logic [7:0]        pass_kb_q, pass_scr_q;

  // Keyboard direction: the ena bit gates the handshake directly.
  assign kb_ready_o = csr_kb_i[CSR_ENA];
  assign kb_push    = kb_valid_i && kb_ready_o;
  assign kb_pop     = kb_rd_i && !kb_empty;
  assign kb_ovf     = kb_push && kb_full && !kb_pop;
  assign kb_dba     = !kb_empty;

  // Screen direction: dba means "room to write", not "data present".
  assign scr_push    = scr_wr_i && csr_scr_i[CSR_ENA];
  assign scr_valid_o = !scr_empty && csr_scr_i[CSR_ENA];
  assign scr_pop     = scr_valid_o && scr_ready_i;
  assign scr_ovf     = scr_push && scr_full && !scr_pop;
  assign scr_dba     = !scr_full;

  sync_fifo #(.DATA_W(DATA_W), .DEPTH(DEPTH)) u_kb_fifo (
    .clk     (clk),
    .rst     (rst),
    .push_i  (kb_push),
    .pop_i   (kb_pop),
    .data_i  (kb_data_i),
    .head_o  (kb_head),
    .full_o  (kb_full),
    .empty_o (kb_empty),
    .count_o (kb_count)
  );

  sync_fifo #(.DATA_W(DATA_W), .DEPTH(DEPTH)) u_scr_fifo (
    .clk     (clk),
    .rst     (rst),
    .push_i  (scr_push),
    .pop_i   (scr_pop),
    .data_i  (data_reg_scr_i),
    .head_o  (scr_head),
    .full_o  (scr_full),
    .empty_o (scr_empty),
    .count_o (scr_count)
  );

  // Storage is unreset, so mask the head while empty to present a clean 0.
  assign data_reg_kb_o = kb_empty  ? '0 : kb_head;
  assign scr_data_o    = scr_empty ? '0 : scr_head;

  // Set wins over clear so an overflow in the clearing cycle is not lost.
  assign of_kb_d  = (of_kb_q  && !of_clr_i[0]) || kb_ovf;
  assign of_scr_d = (of_scr_q && !of_clr_i[1]) || scr_ovf;

  always_ff @(posedge clk) begin
    if (rst) begin
      of_kb_q    <= 1'b0;
      of_scr_q   <= 1'b0;
      pass_kb_q  <= CSR_KB_RST  & CSR_PASS_MASK;
      pass_scr_q <= CSR_SCR_RST & CSR_PASS_MASK;
    end else begin
      of_kb_q    <= of_kb_d;
      of_scr_q   <= of_scr_d;
      pass_kb_q  <= csr_kb_i  & CSR_PASS_MASK;
      pass_scr_q <= csr_scr_i & CSR_PASS_MASK;
    end
  end

  assign csr_kb_o  = csr_image(pass_kb_q,  of_kb_q,  kb_dba);
  assign csr_scr_o = csr_image(pass_scr_q, of_scr_q, scr_dba);

`ifdef KB_SCR_FIFO_IRQ_EN
  logic irq_q, irq_d;

  assign irq_d = (csr_kb_i[CSR_IE] && kb_dba) ||
                 (csr_scr_i[CSR_IE] && scr_dba && csr_scr_i[CSR_ENA]);

  always_ff @(posedge clk) begin
    if (rst) irq_q <= 1'b0;
    else     irq_q <= irq_d;
  end

  assign irq_o = irq_q;
`else
  assign irq_o = 1'b0;
`endif

  // Occupancy counts are exposed by the FIFO but not needed here.
  logic unused_counts;
  assign unused_counts = ^{kb_count, scr_count};

endmodule
